// File: rtl/frame_feeder.sv
// frame_feeder: 50%-overlap audio framer feeding an AXI-Stream FFT core.
// Define OFFSET_BINARY_EN to treat audio_in as unsigned offset binary.
module frame_feeder #(
   parameter int FRAME_LEN = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] audio_in,
   input  logic        vld,
   output logic [31:0] m_axis_data_tdata,
   output logic        m_axis_data_tvalid,
   input  logic        m_axis_data_tready,
   output logic        m_axis_data_tlast,
   output logic        frame_drop,
   output logic        busy
);

   localparam int HOP_LEN = FRAME_LEN / 2;
   localparam int DEPTH   = 2 * FRAME_LEN;
   localparam int AW      = $clog2(DEPTH);
   localparam int CW      = $clog2(FRAME_LEN + 1);
   localparam int BW      = $clog2(FRAME_LEN);
   localparam int HW      = $clog2(HOP_LEN);

   localparam logic [CW-1:0] LEN_C     = CW'(FRAME_LEN);
   localparam logic [CW-1:0] LEN_M1    = CW'(FRAME_LEN - 1);
   localparam logic [HW-1:0] HOP_LAST  = HW'(HOP_LEN - 1);
   localparam logic [BW-1:0] BEAT_LAST = BW'(FRAME_LEN - 1);
   localparam logic [AW-1:0] FRAME_OFS = AW'(FRAME_LEN);

   typedef enum logic {IDLE, EMIT} state_t;

   logic [1:0]    rst_sync;
   logic          rst_n;
   logic [11:0]   s12;
   logic [15:0]   s16;
   logic [15:0]   wr_word;
   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] fill;
   logic [HW-1:0] hop;
   logic          trig;
   logic [AW-1:0] start;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] rd_cnt;
   logic [BW-1:0] beat;
   logic          issue;
   logic          adv;
   logic          fire;
   logic          s1_valid;
   logic          s1_last;
   logic [15:0]   s1_data;
   logic          out_valid;
   logic          out_last;
   logic [15:0]   out_data;
   state_t        state_q;
   state_t        state_d;

   // Assert asynchronously, release two clocks after rst rises.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rst_sync <= 2'b00;
      else      rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

`ifdef OFFSET_BINARY_EN
   assign s12 = audio_in - 12'h800;
`else
   assign s12 = audio_in;
`endif
   assign s16     = {{4{s12[11]}}, s12};
   assign wr_word = s16 << 4;

   assign trig = vld && ((fill == LEN_M1) ||
                 ((fill == LEN_C) && (hop == HOP_LAST)));
   assign start = wr_ptr + AW'(1) - FRAME_OFS;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         fill   <= '0;
         hop    <= '0;
      end else if (vld) begin
         wr_ptr <= wr_ptr + AW'(1);
         if (fill != LEN_C)     fill <= fill + CW'(1);
         else if (hop == HOP_LAST) hop <= '0;
         else                   hop <= hop + HW'(1);
      end
   end

   // Sample RAM: not reset, synchronous read port.
   always_ff @(posedge clk) begin
      if (vld)   mem[wr_ptr] <= wr_word;
      if (issue) s1_data     <= mem[rd_ptr];
   end

   // Two-deep pipeline (RAM register, output register) sharing one enable.
   assign adv   = !out_valid || m_axis_data_tready;
   assign fire  = out_valid && m_axis_data_tready;
   assign issue = (state_q == EMIT) && adv && (rd_cnt != LEN_C);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (trig) state_d = EMIT;
         EMIT:    if (fire && (beat == BEAT_LAST)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rd_ptr     <= '0;
         rd_cnt     <= '0;
         beat       <= '0;
         s1_valid   <= 1'b0;
         s1_last    <= 1'b0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_data   <= '0;
         frame_drop <= 1'b0;
      end else begin
         state_q    <= state_d;
         frame_drop <= trig && (state_q == EMIT);
         if ((state_q == IDLE) && trig) begin
            rd_ptr <= start;
            rd_cnt <= '0;
            beat   <= '0;
         end else begin
            if (issue) begin
               rd_ptr <= rd_ptr + AW'(1);
               rd_cnt <= rd_cnt + CW'(1);
            end
            if (fire) beat <= beat + BW'(1);
         end
         if (adv) begin
            s1_valid  <= issue;
            s1_last   <= issue && (rd_cnt == LEN_M1);
            out_valid <= s1_valid;
            out_last  <= s1_valid && s1_last;
            if (s1_valid) out_data <= s1_data;
         end
      end
   end

   assign busy               = (state_q == EMIT);
   assign m_axis_data_tdata  = {16'h0000, out_data};
   assign m_axis_data_tvalid = out_valid;
   assign m_axis_data_tlast  = out_last;

endmodule

// File: tb/tb_frame_feeder.sv
// tb_frame_feeder: randomized bench for frame_feeder (FRAME_LEN=8)
// against a frame-level model built from sample history and counts.
module tb_frame_feeder;

   localparam int FL  = 8;
   localparam int HOP = FL / 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        vld = 1'b0;
   logic        tready = 1'b0;
   logic [11:0] audio_in = '0;
   logic [31:0] tdata;
   logic        tvalid;
   logic        tlast;
   logic        frame_drop;
   logic        busy;

   frame_feeder #(.FRAME_LEN(FL)) dut (
      .clk               (clk),
      .rst               (rst),
      .audio_in          (audio_in),
      .vld               (vld),
      .m_axis_data_tdata (tdata),
      .m_axis_data_tvalid(tvalid),
      .m_axis_data_tready(tready),
      .m_axis_data_tlast (tlast),
      .frame_drop        (frame_drop),
      .busy              (busy)
   );

   always #5 clk = ~clk;

   int          nvec = 0;
   int          nerr = 0;
   logic [15:0] hist[$];
   logic [31:0] firsts[$];
   logic [15:0] exp_frame[FL];
   int          n_wr = 0;
   int          beat = 0;
   int          since = 0;
   int          wr_busy = 0;
   int          frames_done = 0;
   int          drops = 0;
   logic        in_flight = 1'b0;
   logic        lat_pending = 1'b0;
   logic        p_valid = 1'b0;
   logic        p_last = 1'b0;
   logic [31:0] p_data = '0;
   logic [31:0] last_data = '0;

   function automatic logic [15:0] conv(input logic [11:0] a);
      int v;
`ifdef OFFSET_BINARY_EN
      v = int'(a) - 2048;
`else
      v = (a >= 12'h800) ? int'(a) - 4096 : int'(a);
`endif
      v = v * 16;
      return 16'(v);
   endfunction

   task automatic model_reset();
      hist.delete();
      firsts.delete();
      n_wr        = 0;
      beat        = 0;
      wr_busy     = 0;
      in_flight   = 1'b0;
      lat_pending = 1'b0;
      p_valid     = 1'b0;
      p_last      = 1'b0;
      p_data      = '0;
   endtask

   // One clock: drive, advance model, clock, then check outputs.
   task automatic step(input logic v, input logic [11:0] a,
                       input logic r);
      logic fire;
      logic was_busy;
      logic trig;
      logic exp_drop;
      vld      = v;
      audio_in = a;
      tready   = r;
      was_busy = in_flight;
      fire     = p_valid && r;
      exp_drop = 1'b0;
      if (fire) begin
         nvec++;
         if (!in_flight) begin
            nerr++;
            $display("FAIL beat_idle data=%h while no frame due",
                     p_data);
         end else begin
            if (p_data !== {16'h0, exp_frame[beat]} ||
                p_last !== (beat == FL - 1)) begin
               nerr++;
               $display("FAIL beat%0d got %h/%b want %h/%b", beat,
                        p_data, p_last, {16'h0, exp_frame[beat]},
                        (beat == FL - 1));
            end
            if (beat == 0) firsts.push_back(p_data);
            last_data = p_data;
            beat++;
            if (beat == FL) begin
               in_flight = 1'b0;
               frames_done++;
            end
         end
      end
      if (v) begin
         hist.push_back(conv(a));
         n_wr++;
         if (in_flight) wr_busy++;
         trig = (n_wr == FL) ||
                (n_wr > FL && ((n_wr - FL) % HOP) == 0);
         if (trig) begin
            if (was_busy) begin
               exp_drop = 1'b1;
               drops++;
            end else begin
               for (int i = 0; i < FL; i++)
                  exp_frame[i] = hist[hist.size() - FL + i];
               in_flight   = 1'b1;
               beat        = 0;
               since       = 0;
               wr_busy     = 0;
               lat_pending = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      nvec++;
      if (frame_drop !== exp_drop) begin
         nerr++;
         $display("FAIL frame_drop got %b want %b", frame_drop, exp_drop);
      end
      nvec++;
      if (busy !== in_flight) begin
         nerr++;
         $display("FAIL busy got %b want %b", busy, in_flight);
      end
      if (!in_flight) begin
         nvec++;
         if (tvalid !== 1'b0) begin
            nerr++;
            $display("FAIL idle_tvalid got %b want 0", tvalid);
         end
      end
      if (p_valid && !r) begin
         nvec++;
         if (tvalid !== 1'b1 || tdata !== p_data || tlast !== p_last) begin
            nerr++;
            $display("FAIL stall_hold got %b/%h/%b want 1/%h/%b",
                     tvalid, tdata, tlast, p_data, p_last);
         end
      end
      if (fire && in_flight && beat > 0) begin
         nvec++;
         if (tvalid !== 1'b1) begin
            nerr++;
            $display("FAIL gap beat%0d tvalid got %b want 1", beat, tvalid);
         end
      end
      if (in_flight && lat_pending) begin
         if (tvalid) begin
            nvec++;
            lat_pending = 1'b0;
         end else begin
            since++;
            if (since > 3) begin
               nvec++;
               nerr++;
               lat_pending = 1'b0;
               $display("FAIL latency got >3 cycles want <=3");
            end
         end
      end
      p_valid = tvalid;
      p_data  = tdata;
      p_last  = tlast;
   endtask

   task automatic write_sample(input logic [11:0] a, input logic r,
                               input int gap);
      step(1'b1, a, r);
      repeat (gap) step(1'b0, '0, r);
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (in_flight && k < 80) begin
         step(1'b0, '0, 1'b1);
         k++;
      end
      nvec++;
      if (in_flight) begin
         nerr++;
         $display("FAIL drain timeout beat=%0d want %0d", beat, FL);
         in_flight = 1'b0;
      end
      step(1'b0, '0, 1'b1);
   endtask

   task automatic do_reset();
      vld    = 1'b0;
      tready = 1'b0;
      rst    = 1'b0;
      #1;
      nvec++;
      if (tvalid !== 1'b0 || tlast !== 1'b0 || frame_drop !== 1'b0 ||
          busy !== 1'b0 || tdata !== 32'h0) begin
         nerr++;
         $display("FAIL reset got v%b l%b d%b b%b %h want zeros",
                  tvalid, tlast, frame_drop, busy, tdata);
      end
      model_reset();
      repeat (2) step(1'b0, '0, 1'b0);
      rst = 1'b1;
      repeat (3) step(1'b0, '0, 1'b0);
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic test_overlap();
      int          f0;
      logic [31:0] e0;
      logic [31:0] e1;
`ifdef OFFSET_BINARY_EN
      e0 = 32'h0000_8010;
      e1 = 32'h0000_8050;
`else
      e0 = 32'h0000_0010;
      e1 = 32'h0000_0050;
`endif
      do_reset();
      f0 = frames_done;
      for (int i = 1; i <= 12; i++) write_sample(12'(i), 1'b1, 3);
      drain();
      nvec++;
      if (frames_done - f0 != 2 || firsts.size() != 2) begin
         nerr++;
         $display("FAIL overlap_frames got %0d want 2", frames_done - f0);
      end else begin
         nvec++;
         if (firsts[0] !== e0 || firsts[1] !== e1) begin
            nerr++;
            $display("FAIL overlap_first got %h,%h want %h,%h",
                     firsts[0], firsts[1], e0, e1);
         end
      end
   endtask

   task automatic test_stall();
      int          f0;
      int          k;
      logic [3:0]  pat;
      pat = 4'b1001;
      f0  = frames_done;
      k   = 0;
      while (!in_flight && k < 2 * FL) begin
         write_sample(12'($urandom), 1'b1, 0);
         k++;
      end
      k = 0;
      while (in_flight && k < 80) begin
         step(1'b0, '0, pat[3 - (k % 4)]);
         k++;
      end
      drain();
      nvec++;
      if (frames_done - f0 != 1) begin
         nerr++;
         $display("FAIL stall_frames got %0d want 1", frames_done - f0);
      end
   endtask

   task automatic test_drop();
      int f0;
      int d0;
      int k;
      f0 = frames_done;
      d0 = drops;
      k  = 0;
      while (!in_flight && k < 2 * FL) begin
         write_sample(12'($urandom), 1'b0, 1);
         k++;
      end
      for (int i = 0; i < 2 * HOP; i++)
         write_sample(12'($urandom), 1'b0, 1);
      nvec++;
      if (drops - d0 != 2) begin
         nerr++;
         $display("FAIL drop_count got %0d want 2", drops - d0);
      end
      drain();
      nvec++;
      if (frames_done - f0 != 1) begin
         nerr++;
         $display("FAIL drop_frames got %0d want 1", frames_done - f0);
      end
   endtask

   task automatic test_reset_mid();
      int f0;
      int k;
      k = 0;
      while (!in_flight && k < 2 * FL) begin
         write_sample(12'($urandom), 1'b1, 0);
         k++;
      end
      k = 0;
      while (beat < 3 && k < 40) begin
         step(1'b0, '0, 1'b1);
         k++;
      end
      do_reset();
      f0 = frames_done;
      for (int i = 0; i < FL - 1; i++)
         write_sample(12'($urandom), 1'b1, 1);
      nvec++;
      if (busy !== 1'b0) begin
         nerr++;
         $display("FAIL early_frame busy got %b want 0", busy);
      end
      write_sample(12'($urandom), 1'b1, 0);
      drain();
      nvec++;
      if (frames_done - f0 != 1) begin
         nerr++;
         $display("FAIL post_reset_frames got %0d want 1",
                  frames_done - f0);
      end
   endtask

   task automatic test_conv();
      logic [31:0] e801;
      logic [15:0] e800;
`ifdef OFFSET_BINARY_EN
      e801 = 32'h0000_0010;
      e800 = 16'h0000;
`else
      e801 = 32'h0000_8010;
      e800 = 16'h8000;
`endif
      do_reset();
      for (int i = 0; i < FL; i++) write_sample(12'h801, 1'b1, 1);
      drain();
      nvec++;
      if (last_data !== e801) begin
         nerr++;
         $display("FAIL conv_801 got %h want %h", last_data, e801);
      end
      do_reset();
      for (int i = 0; i < FL; i++) write_sample(12'h800, 1'b1, 1);
      drain();
      nvec++;
      if (last_data[15:0] !== e800) begin
         nerr++;
         $display("FAIL conv_800 got %h want %h", last_data[15:0], e800);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3 * FL; i++)
         write_sample(12'($urandom), 1'b1, 0);
      drain();
   endtask

   task automatic test_random();
      logic r;
      for (int i = 0; i < 80; i++) begin
         r = (wr_busy >= 4) ? 1'b1 : ($urandom_range(0, 3) != 0);
         step(1'b1, 12'($urandom), r);
         repeat ($urandom_range(0, 3)) begin
            r = (wr_busy >= 4) ? 1'b1 : ($urandom_range(0, 3) != 0);
            step(1'b0, '0, r);
         end
      end
      drain();
   endtask

   initial begin
      #2;
      test_reset();
      test_overlap();
      test_stall();
      test_drop();
      test_reset_mid();
      test_conv();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule

// File: doc/frame_feeder.md
FRAME_FEEDER -- requirements
Module: frame_feeder

Interface
- REQ-001 Parameter FRAME_LEN, default 1024: FFT frame length in samples; power of two, at least 4.
- REQ-002 Parameter HOP_LEN, fixed at FRAME_LEN/2: new samples per frame, giving 50% overlap.
- REQ-003 clk, input, 1 bit: single clock; all logic is on its rising edge.
- REQ-004 rst, input, 1 bit: reset, asynchronous and active-low.
- REQ-005 audio_in, input, 12 bits: ADC sample, captured when vld=1.
- REQ-006 vld, input, 1 bit: single-cycle sample strobe.
- REQ-007 m_axis_data_tdata, output, 32 bits: [15:0] is the real part, [31:16] is the imaginary part (always 0).
- REQ-008 m_axis_data_tvalid, output, 1 bit: AXI-Stream valid.
- REQ-009 m_axis_data_tready, input, 1 bit: AXI-Stream ready from the FFT core.
- REQ-010 m_axis_data_tlast, output, 1 bit: asserted on the last sample of each frame.
- REQ-011 frame_drop, output, 1 bit: one-cycle pulse when a frame is discarded.
- REQ-012 busy, output, 1 bit: high while in state EMIT.

Function
- REQ-013 Sample storage: circular RAM of 2*FRAME_LEN words, 16 bits each; write pointer wr_ptr is log2(2*FRAME_LEN) bits and wraps modulo 2*FRAME_LEN.
- REQ-014 On vld=1, write conv(audio_in) at wr_ptr, then increment wr_ptr; writes never stall and continue during EMIT.
- REQ-015 conv() output: a 12-bit signed value, sign-extended to 16 bits, then shifted left 4 bits (LSBs zero-filled).
- REQ-016 Frame trigger: fires on the write that brings the total sample count to FRAME_LEN.
  - After that, it fires on every HOP_LEN-th further write.
  - A saturating fill counter gates the first trigger.
- REQ-017 Frame content: the FRAME_LEN most recent samples, oldest first.
  - start = wr_ptr_after_write - FRAME_LEN, modulo 2*FRAME_LEN.
- REQ-018 FSM states:
  - IDLE: on trigger, latch start, clear beat counter, go to EMIT.
  - EMIT: stream FRAME_LEN beats; after the tlast handshake, return to IDLE.
- REQ-019 RAM read is synchronous. The first tvalid is asserted no later than 3 cycles after the trigger write.
- REQ-020 Output handshake:
  - A beat completes only when tvalid and tready are both 1.
  - While tvalid=1 and tready=0, tdata, tlast and tvalid hold stable.
  - tvalid never drops mid-frame while tready is held high.
  - With tready held high, throughput is 1 beat per cycle.
- REQ-021 tlast is 1 only on beat index FRAME_LEN-1.
- REQ-022 Trigger during EMIT:
  - The new frame is dropped, not queued.
  - frame_drop pulses for exactly one cycle.
  - The hop count continues, so the next trigger is still HOP_LEN writes later.
- REQ-023 A trigger on the same cycle as the tlast handshake counts as during EMIT, so it is dropped.
- REQ-024 The 2*FRAME_LEN buffer depth guarantees that no sample in the frame being emitted is overwritten while fewer than FRAME_LEN writes occur during EMIT.

Reset
- REQ-025 On rst=0, asynchronously:
  - tvalid, tlast, frame_drop and busy go to 0; tdata goes to 0.
  - wr_ptr, fill counter, hop counter and beat counter go to 0.
  - The FSM goes to IDLE.
- REQ-026 RAM contents are not reset. After reset, no frame is emitted until FRAME_LEN new samples have been written.
- REQ-027 Reset asserted mid-frame aborts the frame immediately, with no tlast. Reset release is synchronised with a two-flop deassertion stage.

Configuration
- REQ-028 Macro OFFSET_BINARY_EN:
  - Defined: audio_in is unsigned offset binary; conv() first computes audio_in - 2048 (12'h800 maps to 0, 12'hFFF to +2047, 12'h000 to -2048).
  - Undefined: audio_in is taken directly as two's complement.

Verification
- REQ-029 Macro defined, FRAME_LEN=8, tready=1, samples 0..7 of value 12'h801 → one frame of 8 beats, each tdata=32'h0000_0010, tlast only on beat 7, frame_drop=0.
- REQ-030 FRAME_LEN=8, samples 1..12 (macro undefined, tready=1) → frame 1 is 1..8 <<4; frame 2, triggered at sample 12, is 5..12 <<4.
- REQ-031 tready toggled 1,0,0,1 every cycle mid-frame → tdata held during stall cycles; all 8 beats delivered in order with no duplicates.
- REQ-032 tready=0 across two hops → second trigger produces a frame_drop pulse of one cycle; first frame completes intact once tready=1.
- REQ-033 rst pulsed low at beat 3 → tvalid=0 within the same cycle; next frame appears only after 8 further vld writes.
- REQ-034 Macro undefined, audio_in=12'h800 → tdata[15:0]=16'h8000; macro defined, same input → tdata[15:0]=16'h0000.
